// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the ALU and its command-issue stage.
package alu_pkg;

  localparam int alu_sel_width_gp        = 2;
  localparam int alu_done_count_width_gp = 16;

  typedef logic [alu_sel_width_gp-1:0] alu_sel_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// 1-read/1-write command FIFO: read/write pointers plus an occupancy counter.
// The head entry is read straight out of the storage array, so there is no
// read latency and no flow-through from the write port.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int width_p = 10,
  parameter int els_p   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [width_p-1:0] data_in,
  input  logic               pop,
  output logic [width_p-1:0] data_head,
  output logic               full,
  output logic               empty
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);

  logic [width_p-1:0] mem [els_p];
  logic [ptr_w-1:0]   wptr;
  logic [ptr_w-1:0]   rptr;
  logic [cnt_w-1:0]   count;

  assign full      = (count == cnt_w'(els_p));
  assign empty     = (count == '0);
  assign data_head = mem[rptr];

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= data_in;
    end
  end

  // Pointers wrap naturally since els_p is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + ptr_w'(1);
      if (pop)  rptr <= rptr + ptr_w'(1);
      case ({push, pop})
        2'b10:   count <= count + cnt_w'(1);
        2'b01:   count <= count - cnt_w'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_issue.sv
// Command-issue stage in front of the combinational ALU: buffers commands,
// drives the ALU from the FIFO head, and registers the ALU result behind a
// valid/ready handshake. FIFO read, ALU and capture share one cycle.
module alu_cmd_issue
  import alu_pkg::*;
#(
  parameter int width_p = 4,
  parameter int els_p   = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cmd_v_i,
  input  logic [1:0]                         cmd_sel_i,
  input  logic [width_p-1:0]                 cmd_a_i,
  input  logic [width_p-1:0]                 cmd_b_i,
  output logic                               cmd_ready_o,
  output logic [1:0]                         alu_sel_o,
  output logic [width_p-1:0]                 alu_a_o,
  output logic [width_p-1:0]                 alu_b_o,
  input  logic [width_p-1:0]                 alu_res_i,
  output logic                               res_v_o,
  output logic [width_p-1:0]                 res_o,
  output logic [1:0]                         res_sel_o,
  input  logic                               res_ready_i,
  output logic [alu_done_count_width_gp-1:0] done_count_o
);

  localparam int entry_w = alu_sel_width_gp + 2 * width_p;

  logic [entry_w-1:0] cmd_entry;
  logic [entry_w-1:0] head;
  logic               full;
  logic               empty;
  logic               push;
  logic               issue;
  logic               handoff;
  alu_sel_t           head_sel;
  logic [width_p-1:0] head_a;
  logic [width_p-1:0] head_b;

  assign cmd_entry   = {cmd_sel_i, cmd_a_i, cmd_b_i};
  assign cmd_ready_o = ~full & ~reset;
  assign push        = cmd_v_i & cmd_ready_o;
  assign issue       = ~empty & (~res_v_o | res_ready_i);
  assign handoff     = res_v_o & res_ready_i;

  alu_cmd_fifo #(
    .width_p (entry_w),
    .els_p   (els_p)
  ) cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .data_in   (cmd_entry),
    .pop       (issue),
    .data_head (head),
    .full      (full),
    .empty     (empty)
  );

  // Split the head entry and hold the ALU inputs at zero while nothing is queued.
  always_comb begin
    head_sel  = head[entry_w-1 -: alu_sel_width_gp];
    head_a    = head[2*width_p-1 -: width_p];
    head_b    = head[width_p-1:0];
    alu_sel_o = '0;
    alu_a_o   = '0;
    alu_b_o   = '0;
    if (!empty) begin
      alu_sel_o = head_sel;
      alu_a_o   = head_a;
      alu_b_o   = head_b;
    end
  end

  // Result register: capture on issue, otherwise drop valid after a handoff.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_v_o   <= 1'b0;
      res_o     <= '0;
      res_sel_o <= '0;
    end else if (issue) begin
      res_v_o   <= 1'b1;
      res_o     <= alu_res_i;
      res_sel_o <= head_sel;
    end else if (handoff) begin
      res_v_o   <= 1'b0;
    end
  end

  // Count completed handoffs; wraps at the counter width.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_count_o <= '0;
    end else if (handoff) begin
      done_count_o <= done_count_o + alu_done_count_width_gp'(1);
    end
  end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue with an XOR ALU stub on the result path.
module tb_alu_cmd_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_v;
  logic [1:0]  cmd_sel;
  logic [3:0]  cmd_a;
  logic [3:0]  cmd_b;
  logic        cmd_ready;
  logic [1:0]  alu_sel;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [3:0]  alu_res;
  logic        res_v;
  logic [3:0]  res;
  logic [1:0]  res_sel;
  logic        res_ready;
  logic [15:0] done_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign alu_res = alu_a ^ alu_b;

  alu_cmd_issue #(.width_p(4), .els_p(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_v_i      (cmd_v),
    .cmd_sel_i    (cmd_sel),
    .cmd_a_i      (cmd_a),
    .cmd_b_i      (cmd_b),
    .cmd_ready_o  (cmd_ready),
    .alu_sel_o    (alu_sel),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_res_i    (alu_res),
    .res_v_o      (res_v),
    .res_o        (res),
    .res_sel_o    (res_sel),
    .res_ready_i  (res_ready),
    .done_count_o (done_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle to the falling edge for sampling and driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] a, input logic [3:0] b);
    cmd_v   = v;
    cmd_sel = s;
    cmd_a   = a;
    cmd_b   = b;
  endtask

  // Directed command table for the back-pressure test (sel, a, b).
  logic [1:0] bp_sel [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] bp_a   [5] = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
  logic [3:0] bp_b   [5] = '{4'h0, 4'h3, 4'h6, 4'h9, 4'hC};
  logic [3:0] bp_res [5] = '{4'h5, 4'h5, 4'h1, 4'h1, 4'h5};

  initial begin
    int cyc;
    reset     = 1'b1;
    res_ready = 1'b0;
    drive(1'b0, 2'd0, 4'h0, 4'h0);
    @(negedge clk);
    step();
    chk("ready_in_reset", cmd_ready, 0);
    reset = 1'b0;
    step();
    chk("idle_ready", cmd_ready, 1);
    chk("idle_res_v", res_v, 0);
    chk("idle_alu", {alu_sel, alu_a, alu_b}, 0);
    chk("idle_count", done_count, 0);
    chk("idle_res", {res_sel, res}, 0);

    // Single command
    res_ready = 1'b1;
    drive(1'b1, 2'b01, 4'h1, 4'h3);
    step();
    drive(1'b0, 2'd0, 4'h0, 4'h0);
    chk("single_alu_a", alu_a, 4'h1);
    chk("single_alu_b", alu_b, 4'h3);
    chk("single_alu_sel", alu_sel, 2'b01);
    chk("single_res_v_early", res_v, 0);
    step();
    chk("single_res_v", res_v, 1);
    chk("single_res", res, 4'h2);
    chk("single_res_sel", res_sel, 2'b01);
    chk("single_alu_empty", {alu_sel, alu_a, alu_b}, 0);
    step();
    chk("single_count", done_count, 1);
    chk("single_res_v_clr", res_v, 0);
    chk("single_res_hold", res, 4'h2);

    // Back-to-back stream of 8, results follow one cycle behind each push
    for (int k = 0; k < 9; k++) begin
      if (k < 8) begin
        drive(1'b1, 2'(k), 4'(k), 4'hF);
        chk("stream_ready", cmd_ready, 1);
      end else begin
        drive(1'b0, 2'd0, 4'h0, 4'h0);
      end
      step();
      if (k >= 1) begin
        chk("stream_res_v", res_v, 1);
        chk("stream_res", res, 32'((k - 1) ^ 15));
        chk("stream_res_sel", res_sel, 32'((k - 1) % 4));
      end
    end
    step();
    chk("stream_count", done_count, 9);
    chk("stream_res_v_clr", res_v, 0);

    // Back-pressure: first captured, next four fill the FIFO
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, bp_sel[k], bp_a[k], bp_b[k]);
      chk("bp_ready", cmd_ready, 1);
      step();
    end
    drive(1'b1, 2'd3, 4'hE, 4'hE);
    chk("bp_full_ready", cmd_ready, 0);
    step();
    drive(1'b0, 2'd0, 4'h0, 4'h0);
    chk("bp_held_res", res, bp_res[0]);
    chk("bp_held_res_v", res_v, 1);
    chk("bp_head_a", alu_a, bp_a[1]);
    chk("bp_still_full", cmd_ready, 0);
    res_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      step();
      chk("bp_drain_res_v", res_v, 1);
      chk("bp_drain_res", res, bp_res[k]);
      chk("bp_drain_sel", res_sel, bp_sel[k]);
    end
    step();
    chk("bp_drain_end", res_v, 0);
    chk("bp_count", done_count, 14);
    chk("bp_ready_after", cmd_ready, 1);

    // Reset with 3 queued and a pending result
    res_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'd2, 4'(k), 4'h1);
      step();
    end
    drive(1'b0, 2'd0, 4'h0, 4'h0);
    chk("rst_pre_res_v", res_v, 1);
    reset = 1'b1;
    step();
    chk("rst_res_v", res_v, 0);
    chk("rst_alu", {alu_sel, alu_a, alu_b}, 0);
    chk("rst_count", done_count, 0);
    chk("rst_res", {res_sel, res}, 0);
    chk("rst_ready_low", cmd_ready, 0);
    reset = 1'b0;
    res_ready = 1'b1;
    step();
    chk("rst_ready_high", cmd_ready, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_no_stale", res_v, 0);
    end
    chk("rst_count_after", done_count, 0);

    // Counter wrap: stream until 0xFFFF handoffs, then two more
    drive(1'b1, 2'd1, 4'hA, 4'h5);
    cyc = 0;
    while (done_count != 16'hFFFF && cyc < 70000) begin
      step();
      cyc++;
    end
    chk("wrap_reach_ffff", done_count, 16'hFFFF);
    chk("wrap_res_v", res_v, 1);
    chk("wrap_res", res, 4'hF);
    step();
    chk("wrap_zero", done_count, 16'h0000);
    step();
    chk("wrap_one", done_count, 16'h0001);
    drive(1'b0, 2'd0, 4'h0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
